// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg
// Shared types and constants for the instruction-fetch stage and its queue.
// Provides default widths, address/word types, the sequential PC increment,
// boolean constants and the helper that sizes one packed queue entry.
package fetch_queue_unit_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INST_W  = 32;
    localparam int DEF_DEPTH   = 8;
    localparam int NEXT_PC_INC = 4;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_INST_W-1:0] word_t;

    localparam addr_t ZERO_ADDR = '0;
    localparam logic  TRUE      = 1'b1;
    localparam logic  FALSE     = 1'b0;

    // Packed entry layout, MSB first: {inst, cur_pc, mis_pc, pd_tk}
    function automatic int entry_width(input int inst_w, input int addr_w);
        return inst_w + 2 * addr_w + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo
// Generic synchronous FIFO with flush. Storage is not reset; only the
// pointers and occupancy are. Read data is combinational from the head and
// reads as zero while the FIFO is empty.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all entries (takes priority over push/pop)
//   push, wdata   write one entry at the tail (ignored when full)
//   pop           discard the head entry (ignored when empty)
//   rdata         head entry
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full && !flush && !rst;
    assign do_pop  = pop && !empty && !flush && !rst;
    assign rdata   = empty ? '0 : mem[head];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (!do_push && do_pop) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= wdata;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch stage: presents pc to the icache and branch predictor
// every cycle, pushes each non-zero hit with its prediction into a queue,
// and lets decode pop the queue head with a valid/ready handshake. A ROB
// rollback flushes the queue and redirects pc. rdy low freezes everything.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rdy                               global ready (low = hold)
//   if_rb, rob_rb_pc                  rollback request and target
//   cache_rd_en, cache_rd_addr        icache request
//   cache_hit, cache_hit_inst         icache response
//   bp_pb_pc, bp_pb_inst              predictor probe
//   bp_pd_tk, bp_pd_off               predictor result
//   id_valid, id_ready                decode handshake
//   id_inst, id_cur_pc, id_mis_pc,
//   id_pd_tk                          queue head contents
//   q_count                           queue occupancy
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int               ADDR_W = DEF_ADDR_W,
    parameter int               INST_W = DEF_INST_W,
    parameter int               DEPTH  = DEF_DEPTH,
    parameter int               PC_INC = NEXT_PC_INC,
    parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(ZERO_ADDR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   if_rb,
    input  logic [ADDR_W-1:0]      rob_rb_pc,
    output logic                   cache_rd_en,
    output logic [ADDR_W-1:0]      cache_rd_addr,
    input  logic                   cache_hit,
    input  logic [INST_W-1:0]      cache_hit_inst,
    output logic [ADDR_W-1:0]      bp_pb_pc,
    output logic [INST_W-1:0]      bp_pb_inst,
    input  logic                   bp_pd_tk,
    input  logic [ADDR_W-1:0]      bp_pd_off,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INST_W-1:0]      id_inst,
    output logic [ADDR_W-1:0]      id_cur_pc,
    output logic [ADDR_W-1:0]      id_mis_pc,
    output logic                   id_pd_tk,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int ENTRY_W = entry_width(INST_W, ADDR_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  pc_tgt;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  mis_pc;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               do_enq;
    logic               do_deq;
    logic               do_flush;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign pc_seq  = pc + ADDR_W'(PC_INC);
    assign pc_tgt  = pc + bp_pd_off;
    // The alternate target is whichever path the predictor did not choose.
    assign next_pc = bp_pd_tk ? pc_tgt : pc_seq;
    assign mis_pc  = bp_pd_tk ? pc_seq : pc_tgt;

    assign cache_rd_addr = pc;
    assign bp_pb_pc      = pc;
    assign bp_pb_inst    = cache_hit_inst;

    // Fetch stays blocked for the whole full cycle even if decode pops,
    // so the freed slot is only reused on the following cycle.
    assign cache_rd_en = !rst && rdy && !if_rb && !fifo_full;
    assign do_enq      = cache_rd_en && cache_hit && (cache_hit_inst != '0);
    assign id_valid    = !rst && !fifo_empty;
    assign do_deq      = id_valid && id_ready && rdy && !if_rb;
    assign do_flush    = rdy && if_rb;
    assign q_count     = rst ? '0 : fifo_count;

    assign wr_entry = {cache_hit_inst, pc, mis_pc, bp_pd_tk};
    assign {id_inst, id_cur_pc, id_mis_pc, id_pd_tk} = rst ? '0 : head_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RST_PC;
        end else if (rdy == TRUE) begin
            if (if_rb)       pc <= rob_rb_pc;
            else if (do_enq) pc <= next_pc;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (do_flush),
        .push  (do_enq),
        .pop   (do_deq),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit (DEPTH=8, 32-bit PC/inst, PC_INC=4,
// RST_PC=0). Inputs change on the falling edge and outputs are sampled 1ns
// later, so each vector shows the state left by the previous rising edge.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_rb;
    logic [31:0] rob_rb_pc;
    logic        cache_rd_en;
    logic [31:0] cache_rd_addr;
    logic        cache_hit;
    logic [31:0] cache_hit_inst;
    logic [31:0] bp_pb_pc;
    logic [31:0] bp_pb_inst;
    logic        bp_pd_tk;
    logic [31:0] bp_pd_off;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_cur_pc;
    logic [31:0] id_mis_pc;
    logic        id_pd_tk;
    logic [3:0]  q_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W (32),
        .INST_W (32),
        .DEPTH  (8),
        .PC_INC (4),
        .RST_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_rb          (if_rb),
        .rob_rb_pc      (rob_rb_pc),
        .cache_rd_en    (cache_rd_en),
        .cache_rd_addr  (cache_rd_addr),
        .cache_hit      (cache_hit),
        .cache_hit_inst (cache_hit_inst),
        .bp_pb_pc       (bp_pb_pc),
        .bp_pb_inst     (bp_pb_inst),
        .bp_pd_tk       (bp_pd_tk),
        .bp_pd_off      (bp_pd_off),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_cur_pc      (id_cur_pc),
        .id_mis_pc      (id_mis_pc),
        .id_pd_tk       (id_pd_tk),
        .q_count        (q_count)
    );

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        rb;
        logic [31:0] rb_pc;
        logic        hit;
        logic [31:0] inst;
        logic        tk;
        logic [31:0] off;
        logic        ready;
    } in_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] cur;
        logic [31:0] mis;
        logic [31:0] inst;
        logic        tk;
        logic [3:0]  cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs [18];

    function automatic in_t mkIn(input logic r, input logic rd, input logic rb,
                                 input logic [31:0] rbpc, input logic hit,
                                 input logic [31:0] inst, input logic tk,
                                 input logic [31:0] off, input logic ready);
        in_t v;
        v.rst = r; v.rdy = rd; v.rb = rb; v.rb_pc = rbpc; v.hit = hit;
        v.inst = inst; v.tk = tk; v.off = off; v.ready = ready;
        return v;
    endfunction

    function automatic out_t mkOut(input logic en, input logic [31:0] addr,
                                   input logic valid, input logic [31:0] cur,
                                   input logic [31:0] mis, input logic [31:0] inst,
                                   input logic tk, input logic [3:0] cnt);
        out_t v;
        v.en = en; v.addr = addr; v.valid = valid; v.cur = cur; v.mis = mis;
        v.inst = inst; v.tk = tk; v.cnt = cnt;
        return v;
    endfunction

    function automatic out_t sampleOut();
        return mkOut(cache_rd_en, cache_rd_addr, id_valid, id_cur_pc, id_mis_pc,
                     id_inst, id_pd_tk, q_count);
    endfunction

    task automatic applyStimulus(input in_t v);
        @(negedge clk);
        rst            = v.rst;
        rdy            = v.rdy;
        if_rb          = v.rb;
        rob_rb_pc      = v.rb_pc;
        cache_hit      = v.hit;
        cache_hit_inst = v.inst;
        bp_pd_tk       = v.tk;
        bp_pd_off      = v.off;
        id_ready       = v.ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [159:0] act,
                               input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    in_t fillIn;
    in_t drainIn;

    initial begin
        // Stream from pc 0: off 0x40 makes mis = pc+0x40 on not-taken hits.
        vecs[0]  = '{mkIn(1,1,0,0,1,32'h13,0,32'h40,1), mkOut(0,32'h0,0,32'h0,32'h0,32'h0,0,0)};
        vecs[1]  = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,1), mkOut(1,32'h0,0,32'h0,32'h0,32'h0,0,0)};
        vecs[2]  = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,1), mkOut(1,32'h4,1,32'h0,32'h40,32'h13,0,1)};
        vecs[3]  = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,1), mkOut(1,32'h8,1,32'h4,32'h44,32'h13,0,1)};
        // Miss, then zero instruction: nothing enqueued, pc held at 0xC.
        vecs[4]  = '{mkIn(0,1,0,0,0,32'h13,0,32'h40,0), mkOut(1,32'hC,1,32'h8,32'h48,32'h13,0,1)};
        vecs[5]  = '{mkIn(0,1,0,0,1,32'h0,0,32'h40,0),  mkOut(1,32'hC,1,32'h8,32'h48,32'h13,0,1)};
        vecs[6]  = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,0), mkOut(1,32'hC,1,32'h8,32'h48,32'h13,0,1)};
        // Taken branch at 0x10 with offset -8: mis 0x14, next pc 0x08.
        vecs[7]  = '{mkIn(0,1,0,0,1,32'h13,1,32'hFFFFFFF8,0), mkOut(1,32'h10,1,32'h8,32'h48,32'h13,0,2)};
        vecs[8]  = '{mkIn(0,1,0,0,0,32'h13,0,32'h40,1), mkOut(1,32'h8,1,32'h8,32'h48,32'h13,0,3)};
        vecs[9]  = '{mkIn(0,1,0,0,0,32'h13,0,32'h40,1), mkOut(1,32'h8,1,32'hC,32'h4C,32'h13,0,2)};
        // rdy low: frozen, and a rollback during the freeze is ignored.
        vecs[10] = '{mkIn(0,0,0,0,1,32'h13,0,32'h40,1), mkOut(0,32'h8,1,32'h10,32'h14,32'h13,1,1)};
        vecs[11] = '{mkIn(0,0,1,32'h200,1,32'h13,0,32'h40,1), mkOut(0,32'h8,1,32'h10,32'h14,32'h13,1,1)};
        vecs[12] = '{mkIn(0,0,0,0,1,32'h13,0,32'h40,1), mkOut(0,32'h8,1,32'h10,32'h14,32'h13,1,1)};
        vecs[13] = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,1), mkOut(1,32'h8,1,32'h10,32'h14,32'h13,1,1)};
        // Rollback to 0x200 with a non-empty queue.
        vecs[14] = '{mkIn(0,1,1,32'h200,1,32'h13,0,32'h40,1), mkOut(0,32'hC,1,32'h8,32'h48,32'h13,0,1)};
        vecs[15] = '{mkIn(0,1,0,0,1,32'h13,0,32'h40,1), mkOut(1,32'h200,0,32'h0,32'h0,32'h0,0,0)};
        vecs[16] = '{mkIn(0,1,0,0,0,32'h13,0,32'h40,1), mkOut(1,32'h204,1,32'h200,32'h240,32'h13,0,1)};
        vecs[17] = '{mkIn(0,1,0,0,0,32'h13,0,32'h40,1), mkOut(1,32'h204,0,32'h0,32'h0,32'h0,0,0)};

        // Initial reset edge so that vector 0 observes a defined state.
        rst = 1'b1; rdy = 1'b1; if_rb = 1'b0; rob_rb_pc = '0; cache_hit = 1'b0;
        cache_hit_inst = '0; bp_pd_tk = 1'b0; bp_pd_off = '0; id_ready = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].i);
            checkOutput($sformatf("vec%0d", i), 160'(sampleOut()), 160'(vecs[i].o));
        end

        // Fill to full with decode stalled, then drain in order.
        fillIn  = mkIn(0,1,0,0,1,32'h13,0,32'h40,0);
        drainIn = mkIn(0,1,0,0,1,32'h13,0,32'h40,1);
        applyStimulus(mkIn(1,1,0,0,0,32'h0,0,32'h0,0));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(fillIn);
            checkOutput($sformatf("fillAddr%0d", i), 160'(cache_rd_addr), 160'(32'(4 * i)));
            checkOutput($sformatf("fillCount%0d", i), 160'(q_count), 160'(i));
        end
        applyStimulus(fillIn);
        checkOutput("fullCount", 160'(q_count), 160'(8));
        checkOutput("fullRdEn", 160'(cache_rd_en), 160'(0));
        checkOutput("fullPc", 160'(cache_rd_addr), 160'(32'h20));
        checkOutput("fullProbePc", 160'(bp_pb_pc), 160'(32'h20));
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(drainIn);
            checkOutput($sformatf("drainPc%0d", k), 160'(id_cur_pc), 160'(32'(4 * k)));
            if (k == 0) begin
                checkOutput("drainBlockedRdEn", 160'(cache_rd_en), 160'(0));
                checkOutput("drainFullCount", 160'(q_count), 160'(8));
            end else begin
                checkOutput($sformatf("drainFetch%0d", k), 160'(cache_rd_addr),
                            160'(32'h20 + 32'(4 * (k - 1))));
                checkOutput($sformatf("drainCount%0d", k), 160'(q_count), 160'(7));
            end
        end

        // Rollback while full: queue emptied, fetch restarts at 0x100.
        applyStimulus(mkIn(1,1,0,0,0,32'h0,0,32'h0,0));
        for (int i = 0; i < 9; i++) applyStimulus(fillIn);
        checkOutput("rbFullCount", 160'(q_count), 160'(8));
        applyStimulus(mkIn(0,1,1,32'h100,1,32'h13,0,32'h40,1));
        checkOutput("rbRdEn", 160'(cache_rd_en), 160'(0));
        applyStimulus(mkIn(0,1,0,0,0,32'h13,0,32'h40,0));
        checkOutput("rbCount", 160'(q_count), 160'(0));
        checkOutput("rbValid", 160'(id_valid), 160'(0));
        checkOutput("rbHeadData", 160'({id_inst, id_cur_pc}), 160'(0));
        checkOutput("rbAddr", 160'(cache_rd_addr), 160'(32'h100));
        applyStimulus(mkIn(0,1,0,0,1,32'h13,0,32'h40,0));
        checkOutput("rbNoStale", 160'(id_valid), 160'(0));
        applyStimulus(mkIn(0,1,0,0,0,32'h13,0,32'h40,0));
        checkOutput("rbFirstPc", 160'(id_cur_pc), 160'(32'h100));
        checkOutput("rbFirstCount", 160'(q_count), 160'(1));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
